// File: rtl/pdp11_fetch_unit.sv
// PDP-11 instruction fetch: byte-wide flash reads assembled into tagged 16-bit words, show-ahead FIFO to decoder.
// Optional predecode of instr_type enabled by defining PDP11_FETCH_PREDECODE_EN.
module pdp11_fetch_unit #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] RESET_PC   = 16'o000000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        flash_rd,
  output logic [15:0] flash_addr,
  input  logic [7:0]  flash_rdata,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr_word,
  output logic [15:0] instr_pc,
  output logic [1:0]  instr_type
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_LO, S_HI, S_WR} state_e;

  state_e         state_q, state_d;
  logic [15:0]    pc_q, pc_d;
  logic [7:0]     lo_q, lo_d;
  logic [CW-1:0]  count_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [15:0]    word_q [FIFO_DEPTH];
  logic [15:0]    tag_q  [FIFO_DEPTH];
  logic           push, pop, full;
  logic [15:0]    push_word;
  logic           unused_bit;

  assign unused_bit  = redirect_pc[0];
  // count never exceeds FIFO_DEPTH (a power of two), so its MSB alone flags full
  assign full        = count_q[AW];
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign push_word   = {flash_rdata, lo_q};
  assign instr_word  = word_q[rd_ptr_q];
  assign instr_pc    = tag_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    lo_d       = lo_q;
    flash_rd   = 1'b0;
    flash_addr = pc_q;
    push       = 1'b0;
    case (state_q)
      S_LO: if (!halt && !full) begin
        flash_rd = 1'b1;
        state_d  = S_HI;
      end
      S_HI: begin
        flash_rd   = 1'b1;
        flash_addr = {pc_q[15:1], 1'b1};
        lo_d       = flash_rdata;
        state_d    = S_WR;
      end
      S_WR: begin
        push    = 1'b1;
        pc_d    = pc_q + 16'd2;
        state_d = S_LO;
      end
      default: state_d = S_LO;
    endcase
    // redirect discards whatever is in flight
    if (redirect_valid) begin
      pc_d    = {redirect_pc[15:1], 1'b0};
      state_d = S_LO;
      push    = 1'b0;
    end
    if (!reset_n) begin
      flash_rd   = 1'b0;
      flash_addr = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_LO;
      pc_q     <= RESET_PC;
      lo_q     <= 8'h00;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        word_q[i] <= 16'h0000;
        tag_q[i]  <= 16'h0000;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      if (redirect_valid) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          word_q[wr_ptr_q] <= push_word;
          tag_q[wr_ptr_q]  <= pc_q;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

`ifdef PDP11_FETCH_PREDECODE_EN
  logic [1:0] type_q [FIFO_DEPTH];

  function automatic logic [1:0] predecode(input logic [15:0] w);
    if (w[15:12] == 4'b0111)      return 2'd1;
    else if (w[14:12] != 3'b000)  return 2'd0;
    else if (w[14:11] == 4'b0001) return 2'd2;
    else                          return 2'd3;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) type_q[i] <= 2'd0;
    end else if (push && !redirect_valid) begin
      type_q[wr_ptr_q] <= predecode(push_word);
    end
  end

  assign instr_type = type_q[rd_ptr_q];
`else
  assign instr_type = 2'd0;
`endif

endmodule

// File: tb/tb_pdp11_fetch_unit.sv
// Bench for pdp11_fetch_unit: directed timing steps, then random ready/halt/redirect against a word-stream model.
module tb_pdp11_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        flash_rd, flash_rd2;
  logic [15:0] flash_addr, flash_addr2;
  logic [7:0]  flash_rdata, flash_rdata2;
  logic        halt, redirect_valid, instr_ready;
  logic [15:0] redirect_pc;
  logic        instr_valid, instr_valid2;
  logic [15:0] instr_word, instr_pc, instr_word2, instr_pc2;
  logic [1:0]  instr_type, instr_type2;

  logic [7:0]  fmem [0:65535];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pdp11_fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(16'o000000)) u_dut (
    .clk(clk), .reset_n(reset_n), .flash_rd(flash_rd), .flash_addr(flash_addr),
    .flash_rdata(flash_rdata), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .instr_pc(instr_pc), .instr_type(instr_type));

  pdp11_fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .reset_n(reset_n), .flash_rd(flash_rd2), .flash_addr(flash_addr2),
    .flash_rdata(flash_rdata2), .halt(1'b0), .redirect_valid(1'b0),
    .redirect_pc(16'h0000), .instr_valid(instr_valid2), .instr_ready(1'b1),
    .instr_word(instr_word2), .instr_pc(instr_pc2), .instr_type(instr_type2));

  // flash returns data one cycle after the strike; garbage otherwise
  always @(posedge clk) begin
    flash_rdata  <= flash_rd  ? fmem[flash_addr]  : 8'($urandom);
    flash_rdata2 <= flash_rd2 ? fmem[flash_addr2] : 8'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {fmem[a + 16'd1], fmem[a]};
  endfunction

  function automatic logic [1:0] exp_type(input logic [15:0] w);
`ifdef PDP11_FETCH_PREDECODE_EN
    if (w[15:12] == 4'b0111) return 2'd1;
    if (w[14:12] != 3'b000)  return 2'd0;
    if (w[14:11] == 4'b0001) return 2'd2;
    return 2'd3;
`else
    return 2'd0;
`endif
  endfunction

  task automatic set_word(input logic [15:0] a, input logic [15:0] w);
    fmem[a]         = w[7:0];
    fmem[a + 16'd1] = w[15:8];
  endtask

  // leaves the bench 1ns into cycle 0 (first cycle out of reset)
  task automatic do_reset(input logic rdy);
    reset_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; instr_ready = rdy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", instr_valid, 0);
    check("rst_word",  instr_word,  0);
    check("rst_pc",    instr_pc,    0);
    check("rst_type",  instr_type,  0);
    check("rst_rd",    flash_rd,    0);
    check("rst_addr",  flash_addr,  0);
    next();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] pw [4];
    logic [15:0] exp_pc;
    logic        prev_redir;
    int          pops;

    for (int a = 0; a < 65536; a++) fmem[a] = 8'($urandom);
    fmem[0] = 8'h01; fmem[1] = 8'h10; fmem[2] = 8'hC0; fmem[3] = 8'h15;
    fmem[16'hFFFE] = 8'h34; fmem[16'hFFFF] = 8'h12;
    pw = '{16'o010203, 16'o070102, 16'o005001, 16'o000401};
    for (int i = 0; i < 4; i++) set_word(16'h0100 + 16'(2 * i), pw[i]);

    // basic fetch timing and PC wrap
    do_reset(1'b1);
    @(negedge clk); check("c0_rd", flash_rd, 1); check("c0_addr", flash_addr, 0);
    next(); @(negedge clk); check("c1_rd", flash_rd, 1); check("c1_addr", flash_addr, 1);
    next(); @(negedge clk); check("c2_valid", instr_valid, 0);
    next(); @(negedge clk);
    check("c3_valid", instr_valid, 1); check("c3_word", instr_word, 16'h1001); check("c3_pc", instr_pc, 0);
    check("wrap_pc0", instr_pc2, 16'hFFFE); check("wrap_word0", instr_word2, 16'h1234);
    repeat (3) next(); @(negedge clk);
    check("c6_valid", instr_valid, 1); check("c6_word", instr_word, 16'h15C0); check("c6_pc", instr_pc, 2);
    check("wrap_pc1", instr_pc2, 16'h0000); check("wrap_word1", instr_word2, 16'h1001);

    // FIFO full stalls issue; one pop re-enables it next cycle
    do_reset(1'b0);
    repeat (12) next();
    @(negedge clk);
    check("full_valid", instr_valid, 1); check("full_pc", instr_pc, 0); check("full_rd", flash_rd, 0);
    next(); instr_ready = 1'b1;
    @(negedge clk); check("pop_rd", flash_rd, 0); check("pop_pc", instr_pc, 0);
    next(); instr_ready = 1'b0;
    @(negedge clk);
    check("after_pop_pc", instr_pc, 2); check("after_pop_rd", flash_rd, 1); check("after_pop_addr", flash_addr, 4);

    // redirect while in HI with one word buffered
    do_reset(1'b0);
    repeat (4) next();
    redirect_valid = 1'b1; redirect_pc = 16'o001001;
    @(negedge clk); check("hi_addr", flash_addr, 3); check("hi_valid", instr_valid, 1);
    next(); redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_valid", instr_valid, 0); check("redir_rd", flash_rd, 1); check("redir_addr", flash_addr, 16'o001000);
    for (int c = 6; c < 8; c++) begin
      next(); @(negedge clk); check("redir_gap", instr_valid, 0);
    end
    next(); @(negedge clk);
    check("redir_new_valid", instr_valid, 1); check("redir_new_pc", instr_pc, 16'o001000);
    check("redir_new_word", instr_word, mem_word(16'o001000));

    // halt raised during HI: current word completes, no further issue
    do_reset(1'b1);
    @(negedge clk);
    next(); halt = 1'b1;
    @(negedge clk); check("halt_hi_rd", flash_rd, 1); check("halt_hi_addr", flash_addr, 1);
    next(); next(); @(negedge clk);
    check("halt_push_valid", instr_valid, 1); check("halt_push_pc", instr_pc, 0); check("halt_rd3", flash_rd, 0);
    for (int c = 4; c < 7; c++) begin
      next(); @(negedge clk); check("halt_rd", flash_rd, 0);
    end
    next(); halt = 1'b0;
    @(negedge clk); check("unhalt_rd", flash_rd, 1); check("unhalt_addr", flash_addr, 2);

    // predecode classes (expected 0 when the option is off)
    do_reset(1'b1);
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    @(negedge clk);
    next(); redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (3) next();
      @(negedge clk);
      check("pd_valid", instr_valid, 1);
      check("pd_word", instr_word, pw[i]);
`ifdef PDP11_FETCH_PREDECODE_EN
      check("pd_type", instr_type, 32'(i));
`else
      check("pd_type", instr_type, 0);
`endif
    end

    // random traffic against the word-stream model
    do_reset(1'b0);
    exp_pc = 16'h0000; prev_redir = 1'b0; pops = 0;
    for (int c = 0; c < 4000; c++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      halt           = ($urandom_range(0, 9) < 2);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = 16'($urandom);
      @(negedge clk);
      if (prev_redir) check("rnd_flush", instr_valid, 0);
      if (flash_rd && !flash_addr[0]) check("rnd_halt_issue", halt, 0);
      if (instr_valid && instr_ready) begin
        check("rnd_pc",   instr_pc,   exp_pc);
        check("rnd_word", instr_word, mem_word(exp_pc));
        check("rnd_type", instr_type, exp_type(mem_word(exp_pc)));
        exp_pc = exp_pc + 16'd2;
        pops++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[15:1], 1'b0};
      prev_redir = redirect_valid;
      next();
    end
    check("rnd_progress", (pops > 300), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pdp11_fetch_unit.md
# pdp11_fetch_unit

Instruction fetch stage of the PDP-11 pipeline, directly upstream of the instruction decoder. Reads byte-wide flash, assembles little-endian 16-bit instruction words, and tags each word with its PC. Words are buffered in a small FIFO and handed to the decoder over a valid/ready handshake. Supports branch/jump redirect with flush and a pipeline halt input.

## Interface
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2
- RESET_PC, 16'o000000, PC loaded on reset
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- flash_rd  out  1  flash byte read strike
- flash_addr  out  16  flash byte address
- flash_rdata  in  8  read data, valid exactly 1 cycle after flash_rd
- halt  in  1  1 = issue no new fetch
- redirect_valid  in  1  branch taken / jump; load new PC, flush
- redirect_pc  in  16  redirect target; bit 0 ignored
- instr_valid  out  1  FIFO head holds a word
- instr_ready  in  1  decoder accepts head
- instr_word  out  16  head instruction word
- instr_pc  out  16  byte address of head word
- instr_type  out  2  predecoded class (see Configuration)

## Operation
- pc register, 16 bits, always even; increments by 2 modulo 2^16 (16'hFFFE → 16'h0000).
- FSM states: LO, HI, WR.
  - LO: if !halt && count < FIFO_DEPTH: flash_rd=1, flash_addr=pc, → HI; else flash_rd=0, stay.
  - HI: flash_rd=1, flash_addr=pc+1; capture flash_rdata as low byte; → WR.
  - WR: flash_rd=0; push {flash_rdata, low_byte} with tag pc into FIFO; pc ← pc+2; → LO.
- Word assembly: instr_word[7:0] = byte at pc, instr_word[15:8] = byte at pc+1.
- halt only blocks issue in LO; fetch in HI/WR completes and pushes. Output side unaffected by halt.
- FIFO: show-ahead; instr_word/instr_pc/instr_type come from head registers; pop when instr_valid && instr_ready. Push in WR and pop in the same cycle both take effect.
- Redirect (highest priority): on a cycle with redirect_valid=1, at that edge pc ← {redirect_pc[15:1],1'b0}, state ← LO, FIFO emptied, in-flight byte/word discarded (no push). A pop handshake completing in that same cycle is valid: the decoder owns that word. All other entries are dropped.
- Redirect while halt=1: pc loads, FIFO flushes, no issue until halt drops.

## Timing
- Reset: pc=RESET_PC, state=LO, FIFO empty, instr_valid=0, instr_word=0, instr_pc=0, instr_type=0. flash_rd forced 0 while reset_n=0; flash_addr=0.
- Fetch latency: LO issue at cycle N, word visible (instr_valid=1) at cycle N+3 if FIFO was empty.
- Throughput: one word per 3 cycles, sustained while FIFO not full and halt=0.
- FIFO full: LO stalls with flash_rd=0. Issue resumes in the cycle after a pop frees an entry.
- Redirect at cycle N: instr_valid=0 at N+1; new read of redirect target at N+1; first new word valid at N+4.
- Reset mid-fetch: in-flight data discarded; no push.

## Configuration
- PDP11_FETCH_PREDECODE_EN defined: instr_type computed at push from the assembled word and stored in the FIFO.
  - bits[15:12]=4'b0111 → 2'd1 (DOUBLE_OPERAND_2)
  - else bits[14:12]≠3'b000 → 2'd0 (DOUBLE_OPERAND_1)
  - else bits[14:11]=4'b0001 → 2'd2 (SINGLE_OPERAND)
  - else 2'd3 (CONDITIONAL_BRANCH)
- Not defined: instr_type tied to 2'd0; no storage is allocated for it.

## Test plan
- Reset, flash[0..3]=8'h01,8'h10,8'hC0,8'h15, instr_ready=1 → flash_rd high at cycles 0–1, addresses 0,1; word 16'h1001 pc 0 valid at cycle 3; then 16'h15C0 pc 2.
- instr_ready=0, FIFO_DEPTH=2 → exactly two words buffered, flash_rd stays 0. Raise ready for 1 cycle → one pop, next issue on the following cycle.
- Redirect to 16'o001001 while in HI with one word buffered → FIFO empty next cycle, flash_addr=16'o001000, no stale word ever valid.
- RESET_PC=16'hFFFE → words tagged 16'hFFFE then 16'h0000 (wrap).
- halt=1 asserted during HI → current word still pushed, no further flash_rd until halt=0.
- With PDP11_FETCH_PREDECODE_EN: words 16'o010203 / 16'o070102 / 16'o005001 / 16'o000401 → instr_type 0 / 1 / 2 / 3.
